// File: rtl/ucitavanje_uzorka_if.sv
// Sample-loader bus: feature-word input handshake, assembled sample output and status.
interface ucitavanje_uzorka_if #(
  parameter int BROJ_ZNACAJKI = 60,
  parameter int SIRINA        = 16
);
  localparam int BW = $clog2(BROJ_ZNACAJKI + 1);

  logic [SIRINA-1:0]               ulaz_podatak;
  logic                            ulaz_valid;
  logic                            ulaz_spreman;
  logic                            ponisti;
  logic [BROJ_ZNACAJKI*SIRINA-1:0] uzorak;
  logic                            uzorak_valid;
  logic                            uzorak_prihvacen;
  logic [BW-1:0]                   brojac;
  logic                            greska;

  modport master (
    output ulaz_podatak, ulaz_valid, ponisti, uzorak_prihvacen,
    input  ulaz_spreman, uzorak, uzorak_valid, brojac, greska
  );

  modport slave (
    input  ulaz_podatak, ulaz_valid, ponisti, uzorak_prihvacen,
    output ulaz_spreman, uzorak, uzorak_valid, brojac, greska
  );
endinterface

// File: rtl/ucitavanje_uzorka.sv
// Assembles BROJ_ZNACAJKI feature words into one sample vector; one word/cycle, valid the cycle after the last word.
// Holds the full sample (ulaz_spreman=0) until uzorak_prihvacen; optional UZORAK_ZASICENJE_EN zeroes negative words and flags greska.
module ucitavanje_uzorka #(
  parameter int BROJ_ZNACAJKI = 60,
  parameter int SIRINA        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ucitavanje_uzorka_if.slave bus
);
  localparam int BW = $clog2(BROJ_ZNACAJKI + 1);
  localparam logic [BW-1:0] ZADNJI = BW'(BROJ_ZNACAJKI - 1);

  typedef enum logic {
    PUNJENJE = 1'b0,
    PUN      = 1'b1
  } stanje_t;

  stanje_t                         stanje;
  logic [BW-1:0]                   brojac_r;
  logic [BROJ_ZNACAJKI*SIRINA-1:0] uzorak_r;
  logic                            valid_r;
  logic                            spreman_r;
  logic                            prihvat;
  logic [SIRINA-1:0]               upis;

  // Abort wins over a word presented in the same cycle.
  assign prihvat = bus.ulaz_valid & spreman_r & ~bus.ponisti;

`ifdef UZORAK_ZASICENJE_EN
  logic greska_r;
  assign upis = bus.ulaz_podatak[SIRINA-1] ? '0 : bus.ulaz_podatak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      greska_r <= 1'b0;
    end else if (prihvat && bus.ulaz_podatak[SIRINA-1]) begin
      greska_r <= 1'b1;
    end
  end

  assign bus.greska = greska_r;
`else
  assign upis       = bus.ulaz_podatak;
  assign bus.greska = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stanje    <= PUNJENJE;
      brojac_r  <= '0;
      uzorak_r  <= '0;
      valid_r   <= 1'b0;
      spreman_r <= 1'b1;
    end else if (bus.ponisti) begin
      stanje    <= PUNJENJE;
      brojac_r  <= '0;
      valid_r   <= 1'b0;
      spreman_r <= 1'b1;
    end else begin
      case (stanje)
        PUNJENJE: begin
          if (prihvat) begin
            for (int k = 0; k < BROJ_ZNACAJKI; k++) begin
              if (brojac_r == BW'(k)) begin
                uzorak_r[k*SIRINA +: SIRINA] <= upis;
              end
            end
            brojac_r <= brojac_r + BW'(1);
            if (brojac_r == ZADNJI) begin
              stanje    <= PUN;
              valid_r   <= 1'b1;
              spreman_r <= 1'b0;
            end
          end
        end
        PUN: begin
          // Sample contents stay in place; the next fill overwrites slot by slot.
          if (bus.uzorak_prihvacen) begin
            stanje    <= PUNJENJE;
            brojac_r  <= '0;
            valid_r   <= 1'b0;
            spreman_r <= 1'b1;
          end
        end
        default: begin
          stanje    <= PUNJENJE;
          spreman_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ulaz_spreman = spreman_r;
  assign bus.uzorak       = uzorak_r;
  assign bus.uzorak_valid = valid_r;
  assign bus.brojac       = brojac_r;
endmodule

// File: tb/tb_ucitavanje_uzorka.sv
// Randomized bench for ucitavanje_uzorka against an array/counter model of the sample loader.
module tb_ucitavanje_uzorka;
  localparam int N = 60;
  localparam int W = 16;

  logic clk;
  logic rst_n;

  ucitavanje_uzorka_if #(.BROJ_ZNACAJKI(N), .SIRINA(W)) bus ();

  ucitavanje_uzorka #(.BROJ_ZNACAJKI(N), .SIRINA(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: slot array, word count, full flag, sticky error.
  logic [W-1:0] m_mem [N];
  int           m_cnt;
  bit           m_full;
  bit           m_greska;

  function automatic logic [W-1:0] stored(input logic [W-1:0] w);
`ifdef UZORAK_ZASICENJE_EN
    return w[W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [N*W-1:0] m_vec();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = m_mem[k];
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < N; k++) m_mem[k] = '0;
    m_cnt = 0; m_full = 0; m_greska = 0;
  endtask

  // Present inputs for one rising edge, advance the model, return at the following falling edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic pon, input logic prih);
    bus.ulaz_valid = v; bus.ulaz_podatak = d; bus.ponisti = pon; bus.uzorak_prihvacen = prih;
    @(posedge clk);
    if (pon) begin
      m_cnt = 0; m_full = 0;
    end else if (!m_full && v) begin
      m_mem[m_cnt] = stored(d);
`ifdef UZORAK_ZASICENJE_EN
      if (d[W-1]) m_greska = 1;
`endif
      m_cnt++;
      if (m_cnt == N) m_full = 1;
    end else if (m_full && prih) begin
      m_full = 0; m_cnt = 0;
    end
    @(negedge clk);
    bus.ulaz_valid = 0; bus.ponisti = 0; bus.uzorak_prihvacen = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.brojac !== 6'd0) $display("FAIL reset_brojac got %0d want 0", bus.brojac); else n_pass++;
    n_checks++; if (bus.uzorak_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.uzorak_valid); else n_pass++;
    n_checks++; if (bus.ulaz_spreman !== 1'b1) $display("FAIL reset_spreman got %b want 1", bus.ulaz_spreman); else n_pass++;
    n_checks++; if (bus.uzorak !== '0) $display("FAIL reset_uzorak got nonzero want 0"); else n_pass++;
    n_checks++; if (bus.greska !== 1'b0) $display("FAIL reset_greska got %b want 0", bus.greska); else n_pass++;
    rst_n = 1'b1;
    cyc(0, '0, 0, 0);
    n_checks++; if (bus.ulaz_spreman !== 1'b1) $display("FAIL post_reset_spreman got %b want 1", bus.ulaz_spreman); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) begin
      cyc(1, W'(k + 1), 0, 0);
      if (k == N - 2) begin
        n_checks++; if (bus.uzorak_valid !== 1'b0) $display("FAIL b2b_early_valid got %b want 0", bus.uzorak_valid); else n_pass++;
      end
    end
    v = bus.uzorak;
    n_checks++; if (bus.uzorak_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", bus.uzorak_valid); else n_pass++;
    n_checks++; if (v[15:0] !== 16'h0001) $display("FAIL b2b_slot0 got %h want 0001", v[15:0]); else n_pass++;
    n_checks++; if (v[959:944] !== 16'h003C) $display("FAIL b2b_slot59 got %h want 003c", v[959:944]); else n_pass++;
    n_checks++; if (bus.brojac !== 6'd60) $display("FAIL b2b_brojac got %0d want 60", bus.brojac); else n_pass++;
    n_checks++; if (v !== m_vec()) $display("FAIL b2b_vector mismatch in sample contents"); else n_pass++;
  endtask

  task automatic test_hold();
    logic [N*W-1:0] snap;
    snap = m_vec();
    for (int i = 0; i < 10; i++) begin
      cyc(1, W'($urandom), 0, 0);
      n_checks++; if (bus.ulaz_spreman !== 1'b0) $display("FAIL hold_spreman cyc %0d got %b want 0", i, bus.ulaz_spreman); else n_pass++;
      n_checks++; if (bus.uzorak !== snap || bus.brojac !== 6'd60) $display("FAIL hold_stable cyc %0d brojac %0d want 60 or data changed", i, bus.brojac); else n_pass++;
    end
    cyc(0, '0, 0, 1);
    n_checks++; if (bus.uzorak_valid !== 1'b0) $display("FAIL release_valid got %b want 0", bus.uzorak_valid); else n_pass++;
    n_checks++; if (bus.ulaz_spreman !== 1'b1) $display("FAIL release_spreman got %b want 1", bus.ulaz_spreman); else n_pass++;
    n_checks++; if (bus.brojac !== 6'd0) $display("FAIL release_brojac got %0d want 0", bus.brojac); else n_pass++;
    n_checks++; if (bus.uzorak !== snap) $display("FAIL release_retained sample cleared or changed"); else n_pass++;
    // Acknowledge while filling is ignored; the word is still taken.
    cyc(1, 16'h1234, 0, 1);
    n_checks++; if (bus.brojac !== 6'(m_cnt) || bus.uzorak[15:0] !== 16'h1234) $display("FAIL prih_in_fill brojac %0d want %0d slot0 %h want 1234", bus.brojac, m_cnt, bus.uzorak[15:0]); else n_pass++;
  endtask

  task automatic test_ponisti();
    cyc(0, '0, 1, 0);
    for (int k = 0; k < 25; k++) cyc(1, W'($urandom) & 16'h7FFF, 0, 0);
    n_checks++; if (bus.brojac !== 6'd25) $display("FAIL abort_pre_brojac got %0d want 25", bus.brojac); else n_pass++;
    cyc(1, 16'h7777, 1, 0);
    n_checks++; if (bus.brojac !== 6'd0) $display("FAIL abort_brojac got %0d want 0", bus.brojac); else n_pass++;
    n_checks++; if (bus.uzorak !== m_vec()) $display("FAIL abort_nowrite slot25 got %h want %h", bus.uzorak[25*W +: W], m_mem[25]); else n_pass++;
  endtask

  task automatic test_gaps();
    int budget;
    budget = 0;
    for (int k = 0; k < N; k++) begin
      int gap;
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) cyc(0, W'($urandom), 0, 0);
      cyc(1, W'($urandom) & 16'h7FFF, 0, 0);
      budget += gap + 1;
    end
    n_checks++; if (bus.uzorak_valid !== 1'b1 || bus.brojac !== 6'd60) $display("FAIL gaps_done valid %b brojac %0d want 1/60", bus.uzorak_valid, bus.brojac); else n_pass++;
    for (int k = 0; k < N; k++) begin
      if (bus.uzorak[k*W +: W] !== m_mem[k]) begin
        n_checks++; $display("FAIL gaps_slot %0d got %h want %h", k, bus.uzorak[k*W +: W], m_mem[k]);
      end
    end
    n_checks++; if (bus.uzorak !== m_vec()) $display("FAIL gaps_vector out of order after %0d cycles", budget); else n_pass++;
    // Abort while holding a full sample.
    cyc(0, '0, 1, 1);
    n_checks++; if (bus.uzorak_valid !== 1'b0 || bus.brojac !== 6'd0 || bus.ulaz_spreman !== 1'b1) $display("FAIL abort_full valid %b brojac %0d spreman %b", bus.uzorak_valid, bus.brojac, bus.ulaz_spreman); else n_pass++;
  endtask

  task automatic test_sign();
    for (int k = 0; k < N; k++) cyc(1, (k == 5) ? 16'h8123 : (W'($urandom) & 16'h7FFF), 0, 0);
`ifdef UZORAK_ZASICENJE_EN
    n_checks++; if (bus.uzorak[95:80] !== 16'h0000) $display("FAIL sign_slot5 got %h want 0000", bus.uzorak[95:80]); else n_pass++;
`else
    n_checks++; if (bus.uzorak[95:80] !== 16'h8123) $display("FAIL sign_slot5 got %h want 8123", bus.uzorak[95:80]); else n_pass++;
`endif
    n_checks++; if (bus.greska !== m_greska) $display("FAIL sign_greska got %b want %b", bus.greska, m_greska); else n_pass++;
    n_checks++; if (bus.uzorak !== m_vec()) $display("FAIL sign_vector sample contents differ"); else n_pass++;
    cyc(0, '0, 0, 1);
    cyc(0, '0, 1, 0);
    n_checks++; if (bus.greska !== m_greska) $display("FAIL sign_sticky got %b want %b", bus.greska, m_greska); else n_pass++;
  endtask

  task automatic test_async_reset();
    cyc(0, '0, 1, 0);
    for (int k = 0; k < 37; k++) cyc(1, W'($urandom), 0, 0);
    n_checks++; if (bus.brojac !== 6'd37) $display("FAIL areset_pre_brojac got %0d want 37", bus.brojac); else n_pass++;
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    n_checks++; if (bus.brojac !== 6'd0) $display("FAIL areset_brojac got %0d want 0", bus.brojac); else n_pass++;
    n_checks++; if (bus.uzorak !== '0) $display("FAIL areset_uzorak got nonzero want 0"); else n_pass++;
    n_checks++; if (bus.uzorak_valid !== 1'b0 || bus.ulaz_spreman !== 1'b1) $display("FAIL areset_flags valid %b spreman %b want 0/1", bus.uzorak_valid, bus.ulaz_spreman); else n_pass++;
    n_checks++; if (bus.greska !== 1'b0) $display("FAIL areset_greska got %b want 0", bus.greska); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 16'h0ABC, 0, 0);
    n_checks++; if (bus.brojac !== 6'd1 || bus.uzorak[15:0] !== 16'h0ABC) $display("FAIL areset_restart brojac %0d slot0 %h want 1/0abc", bus.brojac, bus.uzorak[15:0]); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ulaz_valid = 0; bus.ulaz_podatak = '0; bus.ponisti = 0; bus.uzorak_prihvacen = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_hold();
    test_ponisti();
    test_gaps();
    test_sign();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
